fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/core_pkg.sv | 6 +
 rtl/sklansky_adder.sv | 22 ++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared fetch FSM states and trap-vector mode encodings
package core_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
  localparam logic [1:0] TVEC_DIRECT = 2'b00;
  localparam logic [1:0] TVEC_VECTORED = 2'b01;
endpackage

// File: rtl/sklansky_adder.sv
// sklansky_adder: parallel-prefix adder, carry-in zero, carry-out dropped
module sklansky_adder #(
  parameter int INPUT_SIZE = 32
) (
  input  logic [INPUT_SIZE-1:0] a,
  input  logic [INPUT_SIZE-1:0] b,
  output logic [INPUT_SIZE-1:0] sum
);
  localparam int L = $clog2(INPUT_SIZE);
  logic [INPUT_SIZE-2:0] g, p;
  always_comb begin
    g = a[INPUT_SIZE-2:0] & b[INPUT_SIZE-2:0];
    p = a[INPUT_SIZE-2:0] ^ b[INPUT_SIZE-2:0];
    for (int k = 0; k < L; k++)
      for (int i = 0; i < INPUT_SIZE - 1; i++)
        if (((i >> k) & 1) == 1) begin
          g[i] = g[i] | (p[i] & g[((i >> k) << k) - 1]);
          p[i] = p[i] & p[((i >> k) << k) - 1];
        end
    sum = (a ^ b) ^ {g, 1'b0};
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing with trap/xret redirects and a single-outstanding instruction fetch
module fetch_unit
  import core_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] RESET_VECTOR = '0,
  parameter int CAUSE_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_req,
  output logic                   busy,
  output logic                   mem_rd_en,
  output logic [DATA_SIZE-1:0]   mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rd_data,
  output logic [31:0]            ir,
  output logic                   ir_valid,
  output logic [DATA_SIZE-1:0]   pc,
  output logic [DATA_SIZE-1:0]   pc_plus_4,
  input  logic                   pc_en,
  input  logic                   pc_src,
  input  logic [DATA_SIZE-1:0]   branch_target,
  input  logic                   trap,
  input  logic                   trap_interrupt,
  input  logic [CAUSE_WIDTH-1:0] trap_cause,
  input  logic [DATA_SIZE-1:0]   tvec,
  input  logic                   mret,
  input  logic                   sret,
  input  logic [DATA_SIZE-1:0]   mepc,
  input  logic [DATA_SIZE-1:0]   sepc,
  output logic                   misaligned,
  output logic [DATA_SIZE-1:0]   misaligned_addr
);
  fetch_state_t state_q, state_d;
  logic [DATA_SIZE-1:0] pc_q, pc_d, addr_q, addr_d, mis_addr_q, mis_addr_d, trap_pc, tgt;
  logic [31:0] ir_q, ir_d;
  logic ir_valid_q, ir_valid_d, rd_en_q, rd_en_d, mis_q, mis_d, take, aligned, redirect;
  sklansky_adder #(.INPUT_SIZE(DATA_SIZE)) u_inc (
    .a(pc_q),
    .b(DATA_SIZE'(4)),
    .sum(pc_plus_4)
  );
  // a misaligned xret leaves the PC alone, so it is not a redirect and cannot abort a fetch
  always_comb begin
    trap_pc = {tvec[DATA_SIZE-1:2], 2'b00} +
              ((tvec[1:0] == TVEC_VECTORED && trap_interrupt) ? DATA_SIZE'({trap_cause, 2'b00}) : '0);
    tgt = mret ? mepc : sret ? sepc : pc_src ? branch_target : pc_plus_4;
    take = mret | sret | pc_en;
    aligned = tgt[1:0] == 2'b00;
    redirect = trap | ((mret | sret) & aligned);
    pc_d = trap ? trap_pc : (take && aligned) ? tgt : pc_q;
    mis_d = !trap && take && !aligned;
    mis_addr_d = mis_d ? tgt : mis_addr_q;
    state_d = state_q;
    addr_d = addr_q;
    ir_d = ir_q;
    ir_valid_d = ir_valid_q;
    if (state_q == IDLE && fetch_req) begin
      state_d = FETCH;
      addr_d = pc_q;
      ir_valid_d = 1'b0;
    end
    if (state_q == FETCH) begin
      state_d = mem_ack ? IDLE : redirect ? DRAIN : FETCH;
      ir_d = (mem_ack && !redirect) ? mem_rd_data : ir_q;
      ir_valid_d = (mem_ack && !redirect) ? 1'b1 : ir_valid_q;
    end
    if (state_q == DRAIN && mem_ack) state_d = IDLE;
    rd_en_d = state_d != IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      pc_q <= RESET_VECTOR;
      addr_q <= RESET_VECTOR;
      ir_q <= '0;
      ir_valid_q <= 1'b0;
      rd_en_q <= 1'b0;
      mis_q <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      ir_q <= ir_d;
      ir_valid_q <= ir_valid_d;
      rd_en_q <= rd_en_d;
      mis_q <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  assign busy = state_q != IDLE;
  assign mem_rd_en = rd_en_q;
  assign mem_addr = addr_q;
  assign ir = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc = pc_q;
  assign misaligned = mis_q;
  assign misaligned_addr = mis_addr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed spec scenarios plus random traffic against a queue-based reference model
module tb_fetch_unit;
  typedef struct packed {
    logic fr, ack;
    logic [31:0] data;
    logic pc_en, pc_src;
    logic [31:0] bt;
    logic trap, intr;
    logic [5:0] cause;
    logic [31:0] tvec;
    logic mret, sret;
    logic [31:0] mepc, sepc;
  } stim_t;
  logic clock = 1'b0, reset = 1'b0;
  logic fetch_req = 0, mem_ack = 0, pc_en = 0, pc_src = 0, trap = 0, trap_interrupt = 0, mret = 0, sret = 0;
  logic [31:0] mem_rd_data = '0, branch_target = '0, tvec = '0, mepc = '0, sepc = '0;
  logic [5:0] trap_cause = '0;
  logic busy, mem_rd_en, ir_valid, misaligned;
  logic [31:0] mem_addr, ir, pc, pc_plus_4, misaligned_addr;
  logic pc_en64 = 1'b0;
  logic busy64, rd64, irv64, mis64;
  logic [31:0] ir64;
  logic [63:0] addr64, pc64, pcp64, misa64;
  int checks = 0, errors = 0;
  logic [31:0] exp_ir[$], exp_mis[$];
  logic [31:0] m_pc, m_addr, m_ir, m_mis_addr;
  logic m_irv, m_out, m_drain, m_mis;
  logic prev_v = 1'b0;
  fetch_unit dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .busy(busy), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data), .ir(ir), .ir_valid(ir_valid),
    .pc(pc), .pc_plus_4(pc_plus_4), .pc_en(pc_en), .pc_src(pc_src), .branch_target(branch_target),
    .trap(trap), .trap_interrupt(trap_interrupt), .trap_cause(trap_cause), .tvec(tvec),
    .mret(mret), .sret(sret), .mepc(mepc), .sepc(sepc),
    .misaligned(misaligned), .misaligned_addr(misaligned_addr)
  );
  fetch_unit #(.DATA_SIZE(64), .RESET_VECTOR(64'hFFFF_FFFF_FFFF_FFFC)) dut64 (
    .clock(clock), .reset(reset), .fetch_req(1'b0), .busy(busy64), .mem_rd_en(rd64),
    .mem_addr(addr64), .mem_ack(1'b0), .mem_rd_data(32'h0), .ir(ir64), .ir_valid(irv64),
    .pc(pc64), .pc_plus_4(pcp64), .pc_en(pc_en64), .pc_src(1'b0), .branch_target(64'h0),
    .trap(1'b0), .trap_interrupt(1'b0), .trap_cause(6'h0), .tvec(64'h0),
    .mret(1'b0), .sret(1'b0), .mepc(64'h0), .sepc(64'h0),
    .misaligned(mis64), .misaligned_addr(misa64)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=output expected=none", name);
  endtask
  // monitor: every delivered instruction and misaligned pulse must match a queued expectation
  always @(negedge clock) begin
    if (reset) begin
      if (ir_valid && !prev_v) begin
        if (exp_ir.size() == 0) miss("ir_deliver");
        else chk("ir_deliver", ir, exp_ir.pop_front());
      end
      if (misaligned) begin
        if (exp_mis.size() == 0) miss("mis_pulse");
        else chk("mis_pulse", misaligned_addr, exp_mis.pop_front());
      end
    end
    prev_v = reset && ir_valid;
  end
  task automatic model_reset();
    m_pc = 0; m_addr = 0; m_ir = 0; m_mis_addr = 0;
    m_irv = 0; m_out = 0; m_drain = 0; m_mis = 0;
    exp_ir.delete();
    exp_mis.delete();
  endtask
  task automatic model_step(input stim_t s);
    logic [31:0] t, npc;
    logic redir;
    redir = 0;
    npc = m_pc;
    m_mis = 0;
    if (s.trap) begin
      t = (s.tvec & ~32'd3) + ((s.tvec % 4 == 1 && s.intr) ? 32'(s.cause) * 4 : 32'd0);
      npc = t;
      redir = 1;
    end else if (s.mret || s.sret || s.pc_en) begin
      t = s.mret ? s.mepc : s.sret ? s.sepc : s.pc_src ? s.bt : m_pc + 32'd4;
      if (t % 4 != 0) begin
        m_mis = 1;
        m_mis_addr = t;
        exp_mis.push_back(t);
      end else begin
        npc = t;
        redir = s.mret || s.sret;
      end
    end
    if (!m_out) begin
      if (s.fr) begin m_out = 1; m_drain = 0; m_addr = m_pc; m_irv = 0; end
    end else if (m_drain) begin
      if (s.ack) m_out = 0;
    end else if (s.ack) begin
      m_out = 0;
      if (!redir) begin m_ir = s.data; m_irv = 1; exp_ir.push_back(s.data); end
    end else if (redir) m_drain = 1;
    m_pc = npc;
  endtask
  task automatic compare();
    chk("pc", pc, m_pc);
    chk("pc_plus_4", pc_plus_4, 32'(m_pc + 32'd4));
    chk("mem_rd_en", mem_rd_en, m_out);
    chk("busy", busy, m_out);
    if (m_out) chk("mem_addr", mem_addr, m_addr);
    chk("ir_valid", ir_valid, m_irv);
    chk("ir", ir, m_ir);
    chk("misaligned", misaligned, m_mis);
    chk("misaligned_addr", misaligned_addr, m_mis_addr);
  endtask
  task automatic cyc(input stim_t s);
    fetch_req = s.fr; mem_ack = s.ack; mem_rd_data = s.data; pc_en = s.pc_en; pc_src = s.pc_src;
    branch_target = s.bt; trap = s.trap; trap_interrupt = s.intr; trap_cause = s.cause; tvec = s.tvec;
    mret = s.mret; sret = s.sret; mepc = s.mepc; sepc = s.sepc;
    model_step(s);
    @(posedge clock);
    #1;
    compare();
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask
  initial begin
    stim_t s;
    #1;
    model_reset();
    compare();
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("r64_pc", pc64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("r64_pc_plus_4", pcp64, 64'h0);
    pc_en64 = 1'b1;
    @(posedge clock);
    #1;
    pc_en64 = 1'b0;
    chk("r64_wrap", pc64, 64'h0);
    s = '0; s.fr = 1; cyc(s);
    chk("fetch_addr0", mem_addr, 0);
    chk("fetch_rd_en", mem_rd_en, 1);
    s = '0; cyc(s); cyc(s);
    s.ack = 1; s.data = 32'h13; cyc(s);
    chk("fetch_ir", ir, 32'h13);
    chk("fetch_irv", ir_valid, 1);
    chk("fetch_busy", busy, 0);
    s = '0; s.trap = 1; s.intr = 1; s.cause = 7; s.tvec = 32'h101; cyc(s);
    chk("trap_vectored", pc, 32'h11C);
    s.intr = 0; cyc(s);
    chk("trap_direct", pc, 32'h100);
    s = '0; s.mret = 1; s.mepc = 32'h82; cyc(s);
    chk("mret_mis", misaligned, 1);
    chk("mret_mis_addr", misaligned_addr, 32'h82);
    chk("mret_pc_hold", pc, 32'h100);
    s = '0; cyc(s);
    chk("mis_one_cycle", misaligned, 0);
    s.fr = 1; cyc(s);
    s = '0; s.trap = 1; s.tvec = 32'h200; cyc(s);
    chk("drain_rd_en", mem_rd_en, 1);
    chk("drain_addr", mem_addr, 32'h100);
    s = '0; s.ack = 1; s.data = 32'hDEAD_BEEF; cyc(s);
    chk("drain_irv", ir_valid, 0);
    chk("drain_idle", busy, 0);
    s = '0; s.fr = 1; cyc(s);
    s = '0; s.ack = 1; s.data = 32'h1234_5678; s.trap = 1; s.tvec = 32'h300; cyc(s);
    chk("same_cycle_irv", ir_valid, 0);
    chk("same_cycle_idle", busy, 0);
    s = '0; s.fr = 1; cyc(s);
    s = '0; cyc(s);
    do_reset();
    chk("reset_pc", pc, 32'h0);
    s = '0; s.ack = 1; s.data = 32'hCAFE_F00D; cyc(s);
    chk("stray_ack_ir", ir, 32'h0);
    chk("stray_ack_irv", ir_valid, 0);
    for (int n = 0; n < 3000; n++) begin
      s = '0;
      s.fr = 1'($urandom % 2);
      s.ack = m_out ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      s.data = $urandom;
      s.pc_en = ($urandom % 3 == 0);
      s.pc_src = 1'($urandom % 2);
      s.bt = ($urandom % 4 == 0) ? $urandom : ($urandom & ~32'd3);
      s.trap = ($urandom % 16 == 0);
      s.intr = 1'($urandom % 2);
      s.cause = 6'($urandom);
      s.tvec = $urandom;
      s.mret = ($urandom % 16 == 0);
      s.sret = ($urandom % 16 == 0);
      s.mepc = $urandom;
      s.sepc = $urandom;
      if (n % 700 == 699) do_reset();
      else cyc(s);
    end
    s = '0; cyc(s);
    chk("ir_queue_empty", 32'(exp_ir.size()), 0);
    chk("mis_queue_empty", 32'(exp_mis.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
